// File: rtl/i2c_step_1_top.sv
// One-shot I2C master write: START, ADDR+W, ACK slot, DATA, ACK slot, STOP, then DONE.
// A clock divider produces a registered i2c_clk level and a tick enable; nothing else is clocked off it.

module i2c_clk_divider #(
  parameter int HALF_DIV = 50
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_i2c_clk,
  output logic o_wrap,
  output logic o_tick
);
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_i2c_clk;

  assign o_wrap    = (r_cnt == CW'(HALF_DIV - 1));
  assign o_tick    = o_wrap & ~r_i2c_clk;
  assign o_i2c_clk = r_i2c_clk;

  // half-period counter; i2c_clk toggles on each wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= {CW{1'b0}};
      r_i2c_clk <= 1'b0;
    end else if (o_wrap) begin
      r_cnt     <= {CW{1'b0}};
      r_i2c_clk <= ~r_i2c_clk;
    end else begin
      r_cnt     <= r_cnt + CW'(1);
    end
  end
endmodule

module i2c_step_1_top #(
  parameter int         HALF_DIV = 50,
  parameter logic [6:0] ADDR     = 7'h50,
  parameter logic [7:0] DATA     = 8'hAA
) (
  input  logic clk,
  input  logic rst,
  output logic i2c_clk,
  output logic scl,
  output logic sda,
  output logic busy,
  output logic done
);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_RW    = 4'd3;
  localparam logic [3:0] S_ACK1  = 4'd4;
  localparam logic [3:0] S_DATA  = 4'd5;
  localparam logic [3:0] S_ACK2  = 4'd6;
  localparam logic [3:0] S_STOP1 = 4'd7;
  localparam logic [3:0] S_STOP2 = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic       w_i2c_clk;
  logic       w_wrap;
  logic       w_tick;
  logic [3:0] r_state;
  logic [2:0] r_bit;
  logic [3:0] w_state_nxt;
  logic [2:0] w_bit_nxt;
  logic       r_scl;
  logic       r_sda;
  logic       r_busy;
  logic       r_done;

  i2c_clk_divider #(.HALF_DIV(HALF_DIV)) u_div (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .o_i2c_clk (w_i2c_clk),
    .o_wrap    (w_wrap),
    .o_tick    (w_tick)
  );

  function automatic logic f_sda(input logic [3:0] st, input logic [2:0] bidx);
    case (st)
      S_START, S_RW, S_STOP1, S_STOP2: f_sda = 1'b0;
      S_ADDR:                          f_sda = ADDR[bidx];
      S_DATA:                          f_sda = DATA[bidx];
      default:                         f_sda = 1'b1;
    endcase
  endfunction

  function automatic logic f_scl_en(input logic [3:0] st);
    case (st)
      S_ADDR, S_RW, S_ACK1, S_DATA, S_ACK2, S_STOP1: f_scl_en = 1'b1;
      default:                                       f_scl_en = 1'b0;
    endcase
  endfunction

  // bit sequencer; moves only on the tick that raises i2c_clk
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    if (w_tick) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_START;
        S_START: begin w_state_nxt = S_ADDR; w_bit_nxt = 3'd6; end
        S_ADDR:  begin
          if (r_bit == 3'd0) w_state_nxt = S_RW;
          else               w_bit_nxt   = r_bit - 3'd1;
        end
        S_RW:    w_state_nxt = S_ACK1;
        S_ACK1:  begin w_state_nxt = S_DATA; w_bit_nxt = 3'd7; end
        S_DATA:  begin
          if (r_bit == 3'd0) w_state_nxt = S_ACK2;
          else               w_bit_nxt   = r_bit - 3'd1;
        end
        S_ACK2:  w_state_nxt = S_STOP1;
        S_STOP1: w_state_nxt = S_STOP2;
        S_STOP2: w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // state and line outputs update together with the i2c_clk toggle; scl = ~(new i2c_clk) = old i2c_clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_bit   <= 3'd0;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_wrap) begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_scl   <= f_scl_en(w_state_nxt) ? w_i2c_clk : 1'b1;
      r_sda   <= f_sda(w_state_nxt, w_bit_nxt);
      r_busy  <= (w_state_nxt >= S_START) && (w_state_nxt <= S_STOP2);
      r_done  <= (w_state_nxt == S_DONE);
    end else begin
      r_state <= r_state;
    end
  end

  assign i2c_clk = w_i2c_clk;
  assign scl     = r_scl;
  assign sda     = r_sda;
  assign busy    = r_busy;
  assign done    = r_done;
endmodule

// File: tb/tb_i2c_step_1_top.sv
// Directed bench for i2c_step_1_top: reset hold, full frame timing/bit content, stop, mid-frame reset.

module tb_i2c_step_1_top;
  logic clk;
  logic rst;
  logic i2c_clk, scl, sda, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_step_1_top dut (
    .clk     (clk),
    .rst     (rst),
    .i2c_clk (i2c_clk),
    .scl     (scl),
    .sda     (sda),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor statistics, measured in cycles since reset release
  int          ck_rise [3];
  int          n_ck_rise, ck_hi_cnt;
  int          sda_fall0, scl_fall0, sda_last_rise, sda_hi_edges, late_act, n_scl_rise;
  logic        scl_at_fall0, scl_at_last_rise, sda_950, sda_1850;
  logic        busy_60, done_60;
  logic [31:0] bits;

  task automatic monitor(input int ncyc);
    logic p_scl, p_sda, p_ck;
    p_scl = 1'b1; p_sda = 1'b1; p_ck = 1'b0;
    n_ck_rise = 0; ck_hi_cnt = 0; sda_fall0 = -1; scl_fall0 = -1; sda_last_rise = -1;
    sda_hi_edges = 0; late_act = 0; n_scl_rise = 0; bits = 32'd0;
    scl_at_fall0 = 1'b0; scl_at_last_rise = 1'b0; sda_950 = 1'b0; sda_1850 = 1'b0;
    busy_60 = 1'b0; done_60 = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (i2c_clk && !p_ck) begin
        if (n_ck_rise < 3) ck_rise[n_ck_rise] = c;
        n_ck_rise++;
      end
      if (c >= 50 && c < 250 && i2c_clk) ck_hi_cnt++;
      if (!sda && p_sda && sda_fall0 < 0) begin sda_fall0 = c; scl_at_fall0 = scl; end
      if (sda && !p_sda) begin sda_last_rise = c; scl_at_last_rise = scl; end
      if (!scl && p_scl && scl_fall0 < 0) scl_fall0 = c;
      if (scl && !p_scl) begin bits = {bits[30:0], sda}; n_scl_rise++; end
      if (scl && p_scl && (sda != p_sda)) sda_hi_edges++;
      if (c > 2150 && ((sda != p_sda) || (scl != p_scl))) late_act++;
      if (c == 950)  sda_950  = sda;
      if (c == 1850) sda_1850 = sda;
      if (c == 60) begin busy_60 = busy; done_60 = done; end
      p_scl = scl; p_sda = sda; p_ck = i2c_clk;
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    #1 rst = 1'b0;

    // 1. reset held 50 us
    bad = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (scl !== 1'b1 || sda !== 1'b1 || i2c_clk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("reset_hold_bad_cycles", bad, 0);
    check("reset_scl", scl, 1'b1);
    check("reset_sda", sda, 1'b1);

    // 2..5. full frame then 50 us of quiet
    @(negedge clk); rst = 1'b1;
    monitor(7200);
    check("ck_rise0", ck_rise[0], 50);
    check("ck_rise1", ck_rise[1], 150);
    check("ck_rise2", ck_rise[2], 250);
    check("ck_duty_hi", ck_hi_cnt, 100);
    check("start_sda_fall", sda_fall0, 50);
    check("start_scl_high", scl_at_fall0, 1'b1);
    check("scl_first_fall", scl_fall0, 150);
    check("busy_in_frame", busy_60, 1'b1);
    check("done_in_frame", done_60, 1'b0);
    check("scl_pulses", n_scl_rise, 19);
    check("addr_rw_bits", bits[18:11], 32'hA0);
    check("ack1_bit", bits[10], 1'b1);
    check("data_bits", bits[9:2], 32'hAA);
    check("ack2_bit", bits[1], 1'b1);
    check("stop1_bit", bits[0], 1'b0);
    check("sda_ack1_950", sda_950, 1'b1);
    check("sda_ack2_1850", sda_1850, 1'b1);
    check("stop_sda_rise", sda_last_rise, 2150);
    check("stop_scl_high", scl_at_last_rise, 1'b1);
    check("sda_edges_scl_high", sda_hi_edges, 2);
    check("late_activity", late_act, 0);
    check("final_done", done, 1'b1);
    check("final_busy", busy, 1'b0);

    // 6. reset mid-frame at cycle 500 (ADDR bit 3 = 0 on sda)
    rst = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    monitor(500);
    check("mid_sda_before", sda, 1'b0);
    check("mid_busy_before", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_scl", scl, 1'b1);
    check("mid_rst_sda", sda, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ck", i2c_clk, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    monitor(300);
    check("restart_ck_rise0", ck_rise[0], 50);
    check("restart_sda_fall", sda_fall0, 50);
    check("restart_scl_high", scl_at_fall0, 1'b1);
    check("restart_scl_fall", scl_fall0, 150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
